// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_pkg
//  Description : Shared types, constants and helpers for the wait-state
//                Avalon-MM word RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    // Transfer FSM: idle, or counting down stall cycles for a latched request
    typedef enum logic [0:0] {
        MB_IDLE  = 1'b0,
        MB_STALL = 1'b1
    } mem_bus_state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One LFSR step: shift left, feed back the XOR of the tapped bits
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_ram_array.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_ram_array
//  Description : Single-port synchronous word RAM with byte-lane write
//                enables and a registered, read-enabled output.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_ram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = ""
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [3:0]                     i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [31:0]                    i_wdata,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read; output holds until the next enabled read
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/avalon_wait_ram.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_wait_ram
//  Description : Avalon-MM slave word RAM with programmable (optionally
//                pseudo-random) waitrequest stalls, byte-enabled writes,
//                one-cycle read latency and bad-access flagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_wait_ram
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'hBFC0_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter int          RANDOM_WAIT = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int          c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);
    localparam logic [4:0]  c_WAIT_MOD = 5'(WAIT_STATES + 1);
    localparam logic [3:0]  c_WAIT_FIX = 4'(WAIT_STATES);

    mem_bus_state_t r_state;
    mem_bus_state_t w_next_state;

    logic [3:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic [31:0] r_lat_addr;
    logic        r_lat_read;
    logic        r_lat_write;
    logic        r_rd_zero;

    logic        w_req;
    logic        w_same;
    logic        w_accept;
    logic        w_start_stall;
    logic [31:0] w_offset;
    logic [31:0] w_idx_full;
    logic        w_in_range;
    logic        w_bad;
    logic [4:0]  w_mod;
    logic [3:0]  w_n;
    logic        w_ram_we;
    logic        w_ram_re;
    logic [31:0] w_ram_rdata;

    // ---------------- request decode ----------------
    assign w_req      = read | write;
    // Subtraction wraps for addresses below the base; the >= test rejects those
    assign w_offset   = address - ADDR_BASE;
    assign w_idx_full = w_offset >> 2;
    assign w_in_range = (address >= ADDR_BASE) && (w_idx_full < c_DEPTH);
    assign w_bad      = !w_in_range || (read && write);

    // Stall length for a new request: fixed, or LFSR-derived and bounded
    assign w_mod = {1'b0, r_lfsr[3:0]} % c_WAIT_MOD;
    assign w_n   = (RANDOM_WAIT != 0) ? 4'(w_mod) : c_WAIT_FIX;

    // A stalled request must be held unchanged; any change abandons it
    assign w_same = (address == r_lat_addr) && (read == r_lat_read) &&
                    (write == r_lat_write);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MB_IDLE: begin
                if (w_req && (w_n != 4'd0)) begin
                    w_next_state = MB_STALL;
                end
            end
            MB_STALL: begin
                if (!w_same || (r_cnt == 4'd0)) begin
                    w_next_state = MB_IDLE;
                end
            end
            default: w_next_state = MB_IDLE;
        endcase
    end

    // Output logic: accept strobe and stall-start strobe, both blocked in reset
    always_comb begin
        w_accept      = 1'b0;
        w_start_stall = 1'b0;
        if (!reset) begin
            case (r_state)
                MB_IDLE: begin
                    if (w_req) begin
                        if (w_n == 4'd0) begin
                            w_accept = 1'b1;
                        end else begin
                            w_start_stall = 1'b1;
                        end
                    end
                end
                MB_STALL: begin
                    if (w_same && (r_cnt == 4'd0)) begin
                        w_accept = 1'b1;
                    end
                end
                default: begin
                    w_accept      = 1'b0;
                    w_start_stall = 1'b0;
                end
            endcase
        end
    end

    assign waitrequest = ~w_accept;
    assign bus_error   = w_accept & w_bad;

    // Stall counter, request latch and LFSR; LFSR moves only when a stall begins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_lfsr      <= LFSR_SEED;
            r_lat_addr  <= 32'h0;
            r_lat_read  <= 1'b0;
            r_lat_write <= 1'b0;
        end else if (w_start_stall) begin
            r_cnt       <= w_n - 4'd1;
            r_lfsr      <= lfsr_step(r_lfsr);
            r_lat_addr  <= address;
            r_lat_read  <= read;
            r_lat_write <= write;
        end else if ((r_state == MB_STALL) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Memory strobes: only well-formed, in-window accepted transfers touch the RAM
    assign w_ram_we = w_accept && write && !read && w_in_range;
    assign w_ram_re = w_accept && read && !write && w_in_range;

    // Readdata source select: zero after reset or an out-of-window read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_zero <= 1'b1;
        end else if (w_accept && read && !write) begin
            r_rd_zero <= !w_in_range;
        end
    end

    assign readdata = r_rd_zero ? 32'h0 : w_ram_rdata;

    avalon_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_be    (byteenable),
        .i_addr  (w_idx_full[c_AW-1:0]),
        .i_wdata (writedata),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_avalon_wait_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_wait_ram
//  Description : Directed self-checking bench for avalon_wait_ram. Four
//                instances: WAIT_STATES 0, 3, 2 fixed, and 3 with random wait.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_avalon_wait_ram;

    localparam int          c_NDUT = 4;
    localparam logic [31:0] c_BASE = 32'hBFC0_0000;
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] t_addr  [c_NDUT];
    logic        t_rd    [c_NDUT];
    logic        t_wr    [c_NDUT];
    logic [31:0] t_wdata [c_NDUT];
    logic [3:0]  t_be    [c_NDUT];
    logic        t_wait  [c_NDUT];
    logic [31:0] t_rdata [c_NDUT];
    logic        t_err   [c_NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state for the random-wait instance
    logic [15:0] m_lfsr;
    logic [31:0] m_mem [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_NDUT; g++) begin : g_dut
        avalon_wait_ram #(
            .ADDR_BASE   (c_BASE),
            .DEPTH_WORDS (1024),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 2) ? 2 : 3)),
            .RANDOM_WAIT ((g == 3) ? 1 : 0),
            .LFSR_SEED   (c_SEED),
            .INIT_FILE   ("")
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .address     (t_addr[g]),
            .read        (t_rd[g]),
            .write       (t_wr[g]),
            .writedata   (t_wdata[g]),
            .byteenable  (t_be[g]),
            .waitrequest (t_wait[g]),
            .readdata    (t_rdata[g]),
            .bus_error   (t_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Entered and left at posedge+1. Counts waitrequest=1 cycles before acceptance;
    // rdata is readdata in the cycle after the accept.
    task automatic xfer(input int k, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic err, output logic [31:0] rdata);
        bit done;
        done   = 0;
        stalls = 0;
        err    = 1'b0;
        t_addr[k]  = addr;
        t_rd[k]    = rd;
        t_wr[k]    = wr;
        t_wdata[k] = wd;
        t_be[k]    = be;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (t_wait[k] == 1'b0) begin
                done = 1;
                err  = t_err[k];
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("xfer_timeout", 32'(t_wait[k]), 32'd0);
        t_rd[k] = 1'b0;
        t_wr[k] = 1'b0;
        rdata   = t_rdata[k];
    endtask

    initial begin
        int          s;
        logic        e;
        logic [31:0] d;
        logic [31:0] exp_d;
        int          exp_n;

        for (int k = 0; k < c_NDUT; k++) begin
            t_addr[k] = 32'h0; t_rd[k] = 1'b0; t_wr[k] = 1'b0;
            t_wdata[k] = 32'h0; t_be[k] = 4'h0;
        end

        // ---- reset: waitrequest held high even with a request pending ----
        reset     = 1'b1;
        t_rd[0]   = 1'b1;
        t_addr[0] = c_BASE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait", 32'(t_wait[0]), 32'd1);
        check("rst_rdata", t_rdata[1], 32'h0);
        check("rst_err", 32'(t_err[0]), 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        t_rd[0] = 1'b0;

        // ---- WAIT_STATES=0: zero-wait write and read ----
        xfer(0, 1'b0, 1'b1, c_BASE, 32'h3C0A_1234, 4'hF, s, e, d);
        check("ws0_wr_stall", 32'(s), 32'd0);
        xfer(0, 1'b1, 1'b0, c_BASE, 32'h0, 4'h0, s, e, d);
        check("ws0_rd_stall", 32'(s), 32'd0);
        check("ws0_rd_data", d, 32'h3C0A_1234);
        check("ws0_rd_err", 32'(e), 32'd0);

        // ---- WAIT_STATES=3: waitrequest 1,1,1,0 ----
        xfer(1, 1'b0, 1'b1, c_BASE + 32'd4, 32'hA5A5_0001, 4'hF, s, e, d);
        check("ws3_wr_stall", 32'(s), 32'd3);
        xfer(1, 1'b1, 1'b0, c_BASE + 32'd4, 32'h0, 4'h0, s, e, d);
        check("ws3_rd_stall", 32'(s), 32'd3);
        check("ws3_rd_err", 32'(e), 32'd0);
        check("ws3_rd_data", d, 32'hA5A5_0001);

        // ---- WAIT_STATES=2: byte enables ----
        xfer(2, 1'b0, 1'b1, c_BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, s, e, d);
        xfer(2, 1'b0, 1'b1, c_BASE + 32'd8, 32'h0000_0055, 4'h1, s, e, d);
        xfer(2, 1'b1, 1'b0, c_BASE + 32'd8, 32'h0, 4'h0, s, e, d);
        check("be_lane0", d, 32'hDEAD_BE55);
        check("ws2_rd_stall", 32'(s), 32'd2);
        xfer(2, 1'b0, 1'b1, c_BASE + 32'd8, 32'hFFFF_FFFF, 4'h0, s, e, d);
        xfer(2, 1'b1, 1'b0, c_BASE + 32'd8, 32'h0, 4'h0, s, e, d);
        check("be_none", d, 32'hDEAD_BE55);
        xfer(2, 1'b0, 1'b1, c_BASE + 32'd8, 32'h00AB_CD00, 4'h6, s, e, d);
        xfer(2, 1'b1, 1'b0, c_BASE + 32'd8, 32'h0, 4'h0, s, e, d);
        check("be_mid", d, 32'hDEAB_CD55);

        // ---- out-of-window and malformed accesses (WAIT_STATES=0) ----
        xfer(0, 1'b1, 1'b0, 32'hBFBF_FFFC, 32'h0, 4'h0, s, e, d);
        check("oor_lo_err", 32'(e), 32'd1);
        check("oor_lo_data", d, 32'h0);
        @(negedge clk);
        check("oor_err_pulse", 32'(t_err[0]), 32'd0);
        @(posedge clk); #1;
        xfer(0, 1'b1, 1'b0, c_BASE + 32'd4096, 32'h0, 4'h0, s, e, d);
        check("oor_hi_err", 32'(e), 32'd1);
        check("oor_hi_data", d, 32'h0);
        xfer(0, 1'b0, 1'b1, c_BASE + 32'd4096, 32'hFFFF_FFFF, 4'hF, s, e, d);
        check("oor_wr_err", 32'(e), 32'd1);
        xfer(0, 1'b1, 1'b0, c_BASE, 32'h0, 4'h0, s, e, d);
        check("oor_wr_nofx", d, 32'h3C0A_1234);
        xfer(0, 1'b1, 1'b1, c_BASE, 32'h1111_1111, 4'hF, s, e, d);
        check("rdwr_err", 32'(e), 32'd1);
        check("rdwr_rdata_hold", d, 32'h3C0A_1234);
        xfer(0, 1'b1, 1'b0, c_BASE, 32'h0, 4'h0, s, e, d);
        check("rdwr_mem_nofx", d, 32'h3C0A_1234);
        check("rd_ok_err", 32'(e), 32'd0);

        // ---- WAIT_STATES=2: abandon a read after one stall, then write ----
        t_addr[2] = c_BASE + 32'd20;
        t_rd[2]   = 1'b1;
        @(negedge clk);
        check("abn_first_wait", 32'(t_wait[2]), 32'd1);
        @(posedge clk); #1;
        t_rd[2] = 1'b0;
        xfer(2, 1'b0, 1'b1, c_BASE + 32'd20, 32'h0BAD_F00D, 4'hF, s, e, d);
        check("abn_wr_stall", 32'(s), 32'd3);
        check("abn_rdata_hold", d, 32'hDEAB_CD55);
        xfer(2, 1'b1, 1'b0, c_BASE + 32'd20, 32'h0, 4'h0, s, e, d);
        check("abn_rd_data", d, 32'h0BAD_F00D);

        // ---- RANDOM_WAIT=1: reference model for stalls and data ----
        m_lfsr = c_SEED;
        for (int i = 0; i < 216; i++) begin
            logic        op_rd;
            logic [3:0]  w;
            logic [31:0] wd;
            logic [3:0]  be;
            if (i < 16) begin
                op_rd = 1'b0; w = 4'(i); be = 4'hF;
            end else begin
                op_rd = 1'($urandom_range(0, 1)); w = 4'($urandom_range(0, 15));
                be = 4'($urandom_range(0, 15));
            end
            wd    = $urandom;
            exp_n = int'(m_lfsr[3:0]) % 4;
            if (exp_n != 0) m_lfsr = ref_step(m_lfsr);
            xfer(3, op_rd, !op_rd, c_BASE + {26'd0, w, 2'b00}, wd, be, s, e, d);
            check($sformatf("rnd_stall_%0d", i), 32'(s), 32'(exp_n));
            check($sformatf("rnd_err_%0d", i), 32'(e), 32'd0);
            if (op_rd) begin
                check($sformatf("rnd_data_%0d", i), d, m_mem[w]);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) m_mem[w][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end

        // ---- reset in the last stall cycle: write must not commit ----
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_lfsr = c_SEED;
        t_addr[3] = c_BASE; t_wdata[3] = 32'h1234_5678; t_be[3] = 4'hF; t_wr[3] = 1'b1;
        @(negedge clk);
        check("rmid_stall", 32'(t_wait[3]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rmid_wait", 32'(t_wait[3]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        t_wr[3] = 1'b0;
        @(negedge clk);
        check("rmid_rdata_rst", t_rdata[3], 32'h0);
        @(posedge clk); #1;
        exp_n = int'(m_lfsr[3:0]) % 4;
        if (exp_n != 0) m_lfsr = ref_step(m_lfsr);
        exp_d = m_mem[0];
        xfer(3, 1'b1, 1'b0, c_BASE, 32'h0, 4'h0, s, e, d);
        check("rmid_rd_stall", 32'(s), 32'(exp_n));
        check("rmid_no_commit", d, exp_d);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
